multicycle_main_fsm: RTL and testbench
======================================

# multicycle_main_fsm

Main control state machine of the multicycle RISC-V core. Sequences each instruction through fetch, decode, execute, memory and writeback. Steps on the 7-bit opcode held in the instruction register and on the ALU zero flag. Drives every datapath enable and mux select except the immediate-format select, which the instruction decoder produces combinationally from the same opcode.

## Interface
Parameters: none.

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  7  opcode field of the instruction register (IR[6:0])
- zero  in  1  ALU zero flag from the current cycle
- mem_ready  in  1  unified memory has completed the access this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 = PC, 1 = result bus
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR and OldPC capture enable
- reg_write  out  1  register file write enable
- result_src  out  2  result bus select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 (A register), 11 = zero
- alu_src_b  out  2  ALU B select: 00 = rs2 (WriteData register), 01 = ImmExt, 10 = constant 4
- alu_op  out  2  00 = add, 01 = subtract, 10 = decode from funct3/funct7
- illegal_op  out  1  one-cycle pulse when an unrecognised opcode is decoded
- retire  out  1  one-cycle pulse in the final cycle of each completed instruction
- state  out  4  current state code, for debug

## Operation
- Moore machine with a 4-bit state register. All outputs are combinational from state. Exceptions: pc_write, ir_write, mem_write and retire are also qualified by zero or mem_ready as noted below.
- Any output not listed for a state is 0.
- Opcodes: LW 0000011, SW 0100011, R 0110011, I_ALU 0010011, BEQ 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- Per-state outputs and next state:
  - FETCH (0): adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write = pc_write = mem_ready. Goes to DECODE when mem_ready = 1, otherwise holds.
  - DECODE (1): alu_src_a=01, alu_src_b=01, alu_op=00, so ALUOut <= OldPC+imm. Next state by op:
    - LW or SW -> MEMADR
    - R -> EXECUTER
    - I_ALU -> EXECUTEI
    - BEQ -> BEQ
    - JAL -> JAL
    - JALR -> JALR
    - LUI -> LUI
    - AUIPC -> ALUWB (OldPC+imm is already in ALUOut)
    - any other opcode -> FETCH, with illegal_op = 1 for this cycle
  - MEMADR (2): alu_src_a=10, alu_src_b=01, alu_op=00. Goes to MEMREAD for LW, MEMWRITE for SW.
  - MEMREAD (3): adr_src=1, result_src=00. Goes to MEMWB when mem_ready = 1, otherwise holds.
  - MEMWB (4): result_src=01, reg_write=1, retire=1. Goes to FETCH.
  - MEMWRITE (5): adr_src=1, result_src=00, mem_write=1. retire = mem_ready. Goes to FETCH when mem_ready = 1, otherwise holds with mem_write still asserted.
  - EXECUTER (6): alu_src_a=10, alu_src_b=00, alu_op=10. Goes to ALUWB.
  - ALUWB (7): result_src=00, reg_write=1, retire=1. Goes to FETCH.
  - EXECUTEI (8): alu_src_a=10, alu_src_b=01, alu_op=10. Goes to ALUWB.
  - JAL (9): alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. PC <= ALUOut (the target); ALUOut <= OldPC+4. Goes to ALUWB.
  - BEQ (10): alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00. pc_write = zero. retire=1. Goes to FETCH.
  - JALR (11): alu_src_a=10, alu_src_b=01, alu_op=00, so ALUOut <= rs1+imm. Goes to JAL, which is reused for the link and the jump.
  - LUI (12): alu_src_a=11, alu_src_b=01, alu_op=00. Goes to ALUWB.
  - Codes 13–15: all outputs 0; next state FETCH.
- op is sampled in DECODE and MEMADR only. IR is stable outside FETCH.

## Timing
- Reset:
  - rst_n low forces state = FETCH immediately, with no clock edge needed.
  - Outputs during reset and after release are the FETCH values: alu_src_b=10, result_src=10, ir_write = pc_write = mem_ready, all others 0.
  - Reset mid-instruction aborts that instruction. mem_write and reg_write drop combinationally in the same cycle. No retire pulse is produced for the aborted instruction.
- Cycles per instruction with mem_ready held at 1:
  - BEQ 3, AUIPC 3
  - SW 4, R 4, I_ALU 4, JAL 4, LUI 4
  - LW 5, JALR 5
  - illegal opcode 2
- Each cycle of mem_ready = 0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- retire is high for exactly one cycle per completed instruction. It is never high in the same cycle as illegal_op.

## Test plan
- Reset: assert rst_n=0 mid-MEMWRITE with mem_ready=0. Required: state=0 and mem_write=0 in the same cycle. After release with mem_ready=1, ir_write=1 on the first edge.
- LW sequence: op=0000011, mem_ready=1. Required state trace 0,1,2,3,4,0. reg_write=1 and result_src=01 only in state 4. retire pulses once.
- SW with a 2-cycle stall: op=0100011, mem_ready low for 2 cycles in MEMWRITE. Required: state 5 holds for 3 cycles with mem_write=1 throughout. retire only in the third cycle.
- BEQ: op=1100011, run once with zero=1 and once with zero=0. Required: pc_write=1 in state 10 when zero=1, pc_write=0 when zero=0. Both take 3 cycles.
- JALR: op=1100111. Required trace 0,1,11,9,7,0. pc_write=1 in state 9 only (plus FETCH). reg_write=1 in state 7.
- AUIPC, then op=1111111: AUIPC trace 0,1,7,0. The illegal opcode gives trace 0,1,0 with illegal_op=1 in state 1 and no reg_write or mem_write.

Source files
------------

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RISC-V core.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives every datapath enable and mux select except the immediate format.
module multicycle_main_fsm (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       illegal_op,
   output logic       retire,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10,
      S_JALR     = 4'd11,
      S_LUI      = 4'd12
   } state_t;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   // Mux select encodings
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;
   localparam logic [1:0] A_PC       = 2'b00;
   localparam logic [1:0] A_OLDPC    = 2'b01;
   localparam logic [1:0] A_RS1      = 2'b10;
   localparam logic [1:0] A_ZERO     = 2'b11;
   localparam logic [1:0] B_RS2      = 2'b00;
   localparam logic [1:0] B_IMM      = 2'b01;
   localparam logic [1:0] B_FOUR     = 2'b10;
   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_SUB    = 2'b01;
   localparam logic [1:0] ALU_FUNCT  = 2'b10;

   state_t state_q, state_d;

   // State register; reset aborts any in-flight instruction back to FETCH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   assign state = state_q;

   // Next-state and Moore outputs (a few qualified by zero / mem_ready)
   always_comb begin
      state_d    = S_FETCH;
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = A_PC;
      alu_src_b  = B_RS2;
      alu_op     = ALU_ADD;
      illegal_op = 1'b0;
      retire     = 1'b0;
      case (state_q)
         S_FETCH: begin
            // PC <= PC+4 through ALUResult while memory returns the word
            alu_src_a  = A_PC;
            alu_src_b  = B_FOUR;
            result_src = RES_ALURES;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
            state_d    = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            // ALUOut <= OldPC+imm: branch/jump target, and the AUIPC result
            alu_src_a = A_OLDPC;
            alu_src_b = B_IMM;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_IALU:      state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               OP_JALR:      state_d = S_JALR;
               OP_LUI:       state_d = S_LUI;
               OP_AUIPC:     state_d = S_ALUWB;
               default: begin
                  illegal_op = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = A_RS1;
            alu_src_b = B_IMM;
            state_d   = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            state_d = mem_ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            // Strobe stays up through stalls; retires on the accepting cycle
            adr_src   = 1'b1;
            mem_write = 1'b1;
            retire    = mem_ready;
            state_d   = mem_ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXECR: begin
            alu_src_a = A_RS1;
            alu_src_b = B_RS2;
            alu_op    = ALU_FUNCT;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_EXECI: begin
            alu_src_a = A_RS1;
            alu_src_b = B_IMM;
            alu_op    = ALU_FUNCT;
            state_d   = S_ALUWB;
         end
         S_JAL: begin
            // PC <= ALUOut (target) while ALUOut <= OldPC+4 for the link
            alu_src_a = A_OLDPC;
            alu_src_b = B_FOUR;
            pc_write  = 1'b1;
            state_d   = S_ALUWB;
         end
         S_BEQ: begin
            alu_src_a = A_RS1;
            alu_src_b = B_RS2;
            alu_op    = ALU_SUB;
            pc_write  = zero;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_JALR: begin
            // Target rs1+imm lands in ALUOut; JAL then does link and jump
            alu_src_a = A_RS1;
            alu_src_b = B_IMM;
            state_d   = S_JAL;
         end
         S_LUI: begin
            alu_src_a = A_ZERO;
            alu_src_b = B_IMM;
            state_d   = S_ALUWB;
         end
         default: state_d = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for multicycle_main_fsm: walks each instruction class
// cycle by cycle and checks state and control outputs against hand values.
module tb_multicycle_main_fsm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
   logic       illegal_op, retire;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

   multicycle_main_fsm dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .op         (op),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pc_write   (pc_write),
      .adr_src    (adr_src),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .reg_write  (reg_write),
      .result_src (result_src),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .illegal_op (illegal_op),
      .retire     (retire),
      .state      (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one clock; inputs change and outputs are sampled at negedge
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; op = 7'b0000011; zero = 1'b0; mem_ready = 1'b1;
      #12;
      // reset state: FETCH values
      chk("rst.state",      {4'd0, state}, 8'd0);
      chk("rst.ir_write",   {7'd0, ir_write}, 8'd1);
      chk("rst.pc_write",   {7'd0, pc_write}, 8'd1);
      chk("rst.alu_src_b",  {6'd0, alu_src_b}, 8'd2);
      chk("rst.result_src", {6'd0, result_src}, 8'd2);
      chk("rst.misc", {2'd0, adr_src, mem_write, reg_write, illegal_op, retire, 1'b0}, 8'd0);
      chk("rst.a_op", {4'd0, alu_src_a, alu_op}, 8'd0);
      @(negedge clk); rst_n = 1'b1; #1;

      // LW: 0,1,2,3,4,0
      op = 7'b0000011;
      chk("lw.s0",   {4'd0, state}, 8'd0);
      chk("lw.rs0",  {6'd0, result_src}, 8'd2);
      tick();
      chk("lw.s1",   {4'd0, state}, 8'd1);
      chk("lw.dec",  {2'd0, alu_src_a, alu_src_b, alu_op}, 8'b00_01_01_00);
      chk("lw.rw1",  {6'd0, reg_write, retire}, 8'd0);
      tick();
      chk("lw.s2",   {4'd0, state}, 8'd2);
      chk("lw.adr",  {2'd0, alu_src_a, alu_src_b, alu_op}, 8'b00_10_01_00);
      tick();
      chk("lw.s3",   {4'd0, state}, 8'd3);
      chk("lw.rd",   {4'd0, adr_src, reg_write, retire, mem_write}, 8'b0000_1000);
      chk("lw.rs3",  {6'd0, result_src}, 8'd0);
      tick();
      chk("lw.s4",   {4'd0, state}, 8'd4);
      chk("lw.wb",   {5'd0, reg_write, retire, adr_src}, 8'b110);
      chk("lw.rs4",  {6'd0, result_src}, 8'd1);
      tick();
      chk("lw.s5",   {4'd0, state}, 8'd0);
      chk("lw.ret0", {6'd0, reg_write, retire}, 8'd0);

      // SW with two stall cycles in MEMWRITE
      op = 7'b0100011;
      tick(); chk("sw.s1", {4'd0, state}, 8'd1);
      tick(); chk("sw.s2", {4'd0, state}, 8'd2);
      mem_ready = 1'b0;
      tick();
      chk("sw.s5a",  {4'd0, state}, 8'd5);
      chk("sw.mwa",  {5'd0, mem_write, adr_src, retire}, 8'b110);
      tick();
      chk("sw.s5b",  {4'd0, state}, 8'd5);
      chk("sw.mwb",  {5'd0, mem_write, adr_src, retire}, 8'b110);
      mem_ready = 1'b1; #1;
      chk("sw.mwc",  {5'd0, mem_write, reg_write, retire}, 8'b101);
      tick();
      chk("sw.s0",   {4'd0, state}, 8'd0);
      chk("sw.mw0",  {6'd0, mem_write, retire}, 8'd0);

      // BEQ taken then not taken, 3 cycles each
      op = 7'b1100011; zero = 1'b1;
      tick(); chk("beq1.s1", {4'd0, state}, 8'd1);
      tick();
      chk("beq1.s10", {4'd0, state}, 8'd10);
      chk("beq1.ctl", {5'd0, pc_write, retire, reg_write}, 8'b110);
      chk("beq1.alu", {2'd0, alu_src_a, alu_src_b, alu_op}, 8'b00_10_00_01);
      tick(); chk("beq1.s0", {4'd0, state}, 8'd0);
      zero = 1'b0;
      tick(); chk("beq0.s1", {4'd0, state}, 8'd1);
      tick();
      chk("beq0.s10", {4'd0, state}, 8'd10);
      chk("beq0.ctl", {5'd0, pc_write, retire, reg_write}, 8'b010);
      tick(); chk("beq0.s0", {4'd0, state}, 8'd0);

      // JALR: 0,1,11,9,7,0
      op = 7'b1100111;
      tick(); chk("jalr.s1", {4'd0, state}, 8'd1);
      chk("jalr.pw1", {7'd0, pc_write}, 8'd0);
      tick();
      chk("jalr.s11", {4'd0, state}, 8'd11);
      chk("jalr.ctl11", {5'd0, pc_write, reg_write, retire}, 8'd0);
      tick();
      chk("jalr.s9",  {4'd0, state}, 8'd9);
      chk("jalr.ctl9", {5'd0, pc_write, reg_write, retire}, 8'b100);
      chk("jalr.alu9", {2'd0, alu_src_a, alu_src_b, alu_op}, 8'b00_01_10_00);
      tick();
      chk("jalr.s7",  {4'd0, state}, 8'd7);
      chk("jalr.ctl7", {5'd0, pc_write, reg_write, retire}, 8'b011);
      tick(); chk("jalr.s0", {4'd0, state}, 8'd0);

      // AUIPC: 0,1,7,0
      op = 7'b0010111;
      tick(); chk("auipc.s1", {4'd0, state}, 8'd1);
      chk("auipc.ill", {7'd0, illegal_op}, 8'd0);
      tick(); chk("auipc.s7", {4'd0, state}, 8'd7);
      chk("auipc.wb", {6'd0, reg_write, retire}, 8'b11);
      tick(); chk("auipc.s0", {4'd0, state}, 8'd0);

      // illegal opcode: 0,1,0
      op = 7'b1111111;
      tick();
      chk("ill.s1",  {4'd0, state}, 8'd1);
      chk("ill.ctl", {4'd0, illegal_op, retire, reg_write, mem_write}, 8'b1000);
      tick();
      chk("ill.s0",  {4'd0, state}, 8'd0);
      chk("ill.off", {7'd0, illegal_op}, 8'd0);

      // LUI: 0,1,12,7,0
      op = 7'b0110111;
      tick(); tick();
      chk("lui.s12", {4'd0, state}, 8'd12);
      chk("lui.alu", {2'd0, alu_src_a, alu_src_b, alu_op}, 8'b00_11_01_00);
      tick(); chk("lui.s7", {4'd0, state}, 8'd7);
      tick(); chk("lui.s0", {4'd0, state}, 8'd0);

      // FETCH stall: ir_write/pc_write low and state held
      mem_ready = 1'b0; #1;
      chk("fst.en", {6'd0, ir_write, pc_write}, 8'd0);
      tick(); chk("fst.s0", {4'd0, state}, 8'd0);

      // Reset mid-MEMWRITE with mem_ready low
      mem_ready = 1'b1; op = 7'b0100011;
      tick(); tick();
      mem_ready = 1'b0;
      tick();
      chk("rsw.s5", {4'd0, state}, 8'd5);
      rst_n = 1'b0; #1;
      chk("rsw.st", {4'd0, state}, 8'd0);
      chk("rsw.ctl", {5'd0, mem_write, reg_write, retire}, 8'd0);
      @(negedge clk);
      mem_ready = 1'b1; rst_n = 1'b1; #1;
      chk("rsw.irw", {7'd0, ir_write}, 8'd1);
      tick();
      chk("rsw.s1", {4'd0, state}, 8'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
